// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter for the shared register file write port.
// One holding slot per requester, age/round-robin arbitration, registered output stage.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [ADDR_WIDTH-1:0]      req0_addr,
  input  logic [DATA_WIDTH-1:0]      req0_data,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [ADDR_WIDTH-1:0]      req1_addr,
  input  logic [DATA_WIDTH-1:0]      req1_data,
  output logic                       wr_en,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic [(2**ADDR_WIDTH)-1:0] pending_mask
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [NUM_REGS-1:0] ONE_HOT_0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic                  slot0_valid, slot1_valid;
  logic [ADDR_WIDTH-1:0] slot0_addr, slot1_addr;
  logic [DATA_WIDTH-1:0] slot0_data, slot1_data;
  // age_q: slot 1 holds the older entry; tie_q: both entries loaded on the same edge
  logic                  age_q, tie_q, rr_q;

  logic gnt0, gnt1, rr_used;
  logic xfer0, xfer1, load0, load1;
  logic next_valid0, next_valid1;
  logic age_next, tie_next;
  logic [NUM_REGS-1:0] mask;

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    rr_used = 1'b0;
    if (slot0_valid && slot1_valid) begin
      if (tie_q) begin
        rr_used = 1'b1;
        if (rr_q) gnt1 = 1'b1;
        else      gnt0 = 1'b1;
      end else if (age_q) begin
        gnt1 = 1'b1;
      end else begin
        gnt0 = 1'b1;
      end
    end else if (slot0_valid) begin
      gnt0 = 1'b1;
    end else if (slot1_valid) begin
      gnt1 = 1'b1;
    end
  end

  assign req0_ready = ~reset & (~slot0_valid | gnt0);
  assign req1_ready = ~reset & (~slot1_valid | gnt1);

  assign xfer0 = req0_valid & req0_ready;
  assign xfer1 = req1_valid & req1_ready;

  // Address 0 is consumed but never buffered; on a same-address collision the load stage wins.
  assign load1 = xfer1 & (req1_addr != '0);
  assign load0 = xfer0 & (req0_addr != '0) & ~(load1 & (req1_addr == req0_addr));

  assign next_valid0 = load0 | (slot0_valid & ~gnt0);
  assign next_valid1 = load1 | (slot1_valid & ~gnt1);

  always_comb begin
    age_next = age_q;
    tie_next = tie_q;
    if (next_valid0 && next_valid1) begin
      if (load0 && load1) begin
        tie_next = 1'b1;
        age_next = 1'b0;
      end else if (load0) begin
        tie_next = 1'b0;
        age_next = 1'b1;
      end else if (load1) begin
        tie_next = 1'b0;
        age_next = 1'b0;
      end
    end else begin
      tie_next = 1'b0;
      age_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0_valid <= 1'b0;
      slot1_valid <= 1'b0;
      slot0_addr  <= '0;
      slot1_addr  <= '0;
      slot0_data  <= '0;
      slot1_data  <= '0;
      age_q       <= 1'b0;
      tie_q       <= 1'b0;
      rr_q        <= 1'b0;
    end else begin
      slot0_valid <= next_valid0;
      slot1_valid <= next_valid1;
      if (load0) begin
        slot0_addr <= req0_addr;
        slot0_data <= req0_data;
      end
      if (load1) begin
        slot1_addr <= req1_addr;
        slot1_data <= req1_data;
      end
      age_q <= age_next;
      tie_q <= tie_next;
      if (rr_used) rr_q <= ~rr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= gnt0 | gnt1;
      if (gnt1) begin
        wr_addr <= slot1_addr;
        wr_data <= slot1_data;
      end else if (gnt0) begin
        wr_addr <= slot0_addr;
        wr_data <= slot0_data;
      end
    end
  end

  always_comb begin
    mask = '0;
    if (slot0_valid) mask = mask | (ONE_HOT_0 << slot0_addr);
    if (slot1_valid) mask = mask | (ONE_HOT_0 << slot1_addr);
    if (wr_en)       mask = mask | (ONE_HOT_0 << wr_addr);
    mask[0] = 1'b0;
  end

  assign pending_mask = mask;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file on the write port.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pending_mask;

  logic [31:0] rf [32];
  int          wr_count;
  int          n_checks;
  int          n_errors;
  int          snap_count;

  regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pending_mask (pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    wr_count = 0;
  end

  always @(posedge clk) begin
    if (wr_en) begin
      rf[wr_addr] <= wr_data;
      wr_count    <= wr_count + 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [4:0] a, input logic [31:0] d);
    req0_valid = v;
    req0_addr  = a;
    req0_data  = d;
  endtask

  task automatic drive1(input logic v, input logic [4:0] a, input logic [31:0] d);
    req1_valid = v;
    req1_addr  = a;
    req1_data  = d;
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    check_val({tag, "_en"}, wr_en, en);
    if (en) begin
      check_val({tag, "_addr"}, wr_addr, a);
      check_val({tag, "_data"}, wr_data, d);
    end
  endtask

  function automatic logic [31:0] bit_of(input int a);
    return 32'h1 << a;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b0, 5'd0, 32'd0);

    // Reset and release
    #2;
    check_val("rst_ready0", req0_ready, 1'b0);
    check_val("rst_ready1", req1_ready, 1'b0);
    check_val("rst_wr_en", wr_en, 1'b0);
    check_val("rst_mask", pending_mask, 32'h0);
    tick();
    tick();
    check_val("rst_hold_ready0", req0_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_val("idle_wr_en", wr_en, 1'b0);
    check_val("idle_mask", pending_mask, 32'h0);
    check_val("idle_ready0", req0_ready, 1'b1);
    check_val("idle_ready1", req1_ready, 1'b1);

    // Requester 0 back-to-back to register 2
    drive0(1'b1, 5'd2, 32'd42);
    tick();
    check_wr("b2b_a", 1'b0, 5'd0, 32'd0);
    check_val("b2b_a_mask", pending_mask, bit_of(2));
    check_val("b2b_a_ready0", req0_ready, 1'b1);
    drive0(1'b1, 5'd2, 32'd15);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    check_wr("b2b_b", 1'b1, 5'd2, 32'd42);
    check_val("b2b_b_mask", pending_mask, bit_of(2));
    tick();
    check_wr("b2b_c", 1'b1, 5'd2, 32'd15);
    check_val("b2b_c_mask", pending_mask, bit_of(2));
    tick();
    check_wr("b2b_d", 1'b0, 5'd0, 32'd0);
    check_val("b2b_d_mask", pending_mask, 32'h0);
    check_val("b2b_rf2", rf[2], 32'd15);
    check_val("b2b_count", wr_count, 2);

    // Same-edge load, rr pointer at 0: slot 0 first
    drive0(1'b1, 5'd3, 32'd19);
    drive1(1'b1, 5'd4, 32'd7);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b0, 5'd0, 32'd0);
    check_val("tie0_ready0", req0_ready, 1'b1);
    check_val("tie0_ready1", req1_ready, 1'b0);
    check_val("tie0_mask", pending_mask, bit_of(3) | bit_of(4));
    tick();
    check_wr("tie0_first", 1'b1, 5'd3, 32'd19);
    check_val("tie0_ready1_b", req1_ready, 1'b1);
    tick();
    check_wr("tie0_second", 1'b1, 5'd4, 32'd7);
    tick();
    check_wr("tie0_idle", 1'b0, 5'd0, 32'd0);

    // Requester 1 one cycle ahead of requester 0
    drive1(1'b1, 5'd5, 32'd55);
    tick();
    drive1(1'b0, 5'd0, 32'd0);
    drive0(1'b1, 5'd6, 32'd66);
    check_val("order_ready0", req0_ready, 1'b1);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    check_wr("order_first", 1'b1, 5'd5, 32'd55);
    tick();
    check_wr("order_second", 1'b1, 5'd6, 32'd66);
    tick();
    check_wr("order_idle", 1'b0, 5'd0, 32'd0);

    // Same-edge load, rr pointer now 1: slot 1 first
    drive0(1'b1, 5'd8, 32'd80);
    drive1(1'b1, 5'd9, 32'd90);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b0, 5'd0, 32'd0);
    check_val("tie1_ready0", req0_ready, 1'b0);
    check_val("tie1_ready1", req1_ready, 1'b1);
    tick();
    check_wr("tie1_first", 1'b1, 5'd9, 32'd90);
    tick();
    check_wr("tie1_second", 1'b1, 5'd8, 32'd80);
    tick();

    // Age must override the rr pointer once entries have distinct load edges
    drive0(1'b1, 5'd10, 32'd100);
    drive1(1'b1, 5'd11, 32'd110);
    tick();
    check_val("age_a_ready0", req0_ready, 1'b1);
    check_val("age_a_ready1", req1_ready, 1'b0);
    check_val("age_a_mask", pending_mask, bit_of(10) | bit_of(11));
    drive0(1'b1, 5'd12, 32'd120);
    drive1(1'b0, 5'd0, 32'd0);
    tick();
    check_wr("age_b", 1'b1, 5'd10, 32'd100);
    check_val("age_b_ready0", req0_ready, 1'b0);
    check_val("age_b_ready1", req1_ready, 1'b1);
    check_val("age_b_mask", pending_mask, bit_of(10) | bit_of(11) | bit_of(12));
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b1, 5'd13, 32'd130);
    tick();
    drive1(1'b0, 5'd0, 32'd0);
    check_wr("age_c", 1'b1, 5'd11, 32'd110);
    check_val("age_c_ready0", req0_ready, 1'b1);
    check_val("age_c_ready1", req1_ready, 1'b0);
    tick();
    check_wr("age_d", 1'b1, 5'd12, 32'd120);
    tick();
    check_wr("age_e", 1'b1, 5'd13, 32'd130);
    tick();
    check_wr("age_idle", 1'b0, 5'd0, 32'd0);
    check_val("age_idle_mask", pending_mask, 32'h0);

    // Same-edge collision on register 17: load stage wins
    snap_count = wr_count;
    drive0(1'b1, 5'd17, 32'd20);
    drive1(1'b1, 5'd17, 32'd21);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b0, 5'd0, 32'd0);
    check_val("same_mask", pending_mask, bit_of(17));
    check_val("same_ready0", req0_ready, 1'b1);
    tick();
    check_wr("same_wr", 1'b1, 5'd17, 32'd21);
    tick();
    check_wr("same_idle", 1'b0, 5'd0, 32'd0);
    check_val("same_count", wr_count - snap_count, 1);
    check_val("same_rf17", rf[17], 32'd21);

    // Address 0 is consumed silently
    snap_count = wr_count;
    drive0(1'b1, 5'd0, 32'd15);
    check_val("zero_ready0", req0_ready, 1'b1);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    check_val("zero_mask_a", pending_mask, 32'h0);
    check_val("zero_ready0_b", req0_ready, 1'b1);
    tick();
    check_wr("zero_wr", 1'b0, 5'd0, 32'd0);
    check_val("zero_mask_b", pending_mask, 32'h0);
    tick();
    check_val("zero_count", wr_count - snap_count, 0);

    // Reset with both slots occupied
    drive0(1'b1, 5'd20, 32'd1);
    drive1(1'b1, 5'd21, 32'd2);
    tick();
    drive0(1'b0, 5'd0, 32'd0);
    drive1(1'b0, 5'd0, 32'd0);
    check_val("rstmid_mask_a", pending_mask, bit_of(20) | bit_of(21));
    snap_count = wr_count;
    tick();
    check_val("rstmid_wr_en_a", wr_en, 1'b1);
    reset = 1'b1;
    #1;
    check_val("rstmid_wr_en_b", wr_en, 1'b0);
    check_val("rstmid_mask_b", pending_mask, 32'h0);
    check_val("rstmid_ready0", req0_ready, 1'b0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    tick();
    check_val("rstmid_wr_en_c", wr_en, 1'b0);
    check_val("rstmid_mask_c", pending_mask, 32'h0);
    check_val("rstmid_count", wr_count - snap_count, 0);
    check_val("rstmid_rf20", rf[20], 32'd0);
    check_val("rstmid_rf21", rf[21], 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
